// File: rtl/pipelined_cla_addsub.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// pipelined_cla_addsub
//
// Purpose:
//   WIDTH-bit adder/subtractor split into STAGES equal segments, one segment
//   per pipeline stage. Each segment uses GROUP-bit carry-lookahead. The carry
//   between segments crosses a register, so the critical path is one segment
//   wide. A valid/ready handshake on both sides lets bubbles collapse and
//   stalls propagate backward.
//
// Parameters:
//   WIDTH  - operand width in bits
//   STAGES - number of pipeline segments (1..4), WIDTH % STAGES == 0
//   GROUP  - lookahead group size inside a segment; a final partial group
//            is handled, so the segment width need not be a multiple of it
//
// Ports:
//   clk       in   clock, rising edge
//   rst       in   asynchronous active-high reset (clears valid bits only)
//   in_valid  in   operation offered
//   in_ready  out  operation accepted this cycle (combinational)
//   sub       in   1: in1 - in2, 0: in1 + in2 + cin
//   cin       in   carry-in for add, ignored when sub = 1
//   in1, in2  in   operands [WIDTH-1:0]
//   out_valid out  s holds a result
//   out_ready in   consumer takes s this cycle
//   s         out  [WIDTH] carry out, [WIDTH-1:0] sum
// -----------------------------------------------------------------------------
module pipelined_cla_addsub #(
    parameter int WIDTH  = 26,
    parameter int STAGES = 2,
    parameter int GROUP  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             sub,
    input  logic             cin,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   s
);

    localparam int SEG  = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;

    // One segment of carry-lookahead addition. Within a lookahead group every
    // carry is a flat sum-of-products of the group's generate/propagate terms
    // and the group carry-in; group carry-ins chain from group to group.
    function automatic logic [SEG:0] cla_segment(
        input logic [SEG-1:0] a,
        input logic [SEG-1:0] b,
        input logic           c_in
    );
        logic [SEG-1:0] g;
        logic [SEG-1:0] p;
        logic [SEG:0]   c;
        logic           t;
        logic           pp;
        int             base;
        g    = a & b;
        p    = a ^ b;
        c    = '0;
        c[0] = c_in;
        for (int j = 1; j <= SEG; j++) begin
            base = ((j - 1) / GROUP) * GROUP;
            t    = 1'b0;
            pp   = 1'b1;
            // Walk from bit j-1 down to the group base: g_i gated by the
            // propagates above it, pp ends as the group-prefix propagate.
            for (int i = GROUP - 1; i >= 0; i--) begin
                if (base + i < j) begin
                    t  = t | (pp & g[base + i]);
                    pp = pp & p[base + i];
                end
            end
            c[j] = t | (pp & c[base]);
        end
        return {c[SEG], p ^ c[SEG-1:0]};
    endfunction

    // ---------------------------------------------------------------------
    // Handshake: stage k loads when empty or when its content moves on.
    // ---------------------------------------------------------------------
    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] valid_d;
    logic [STAGES-1:0] adv;
    logic [STAGES-1:0] en;
    logic              down_ready;

    always_comb begin
        adv        = '0;
        en         = '0;
        down_ready = out_ready;
        // Resolve from the output stage backward so a draining pipeline
        // frees every stage in the same cycle.
        for (int k = STAGES - 1; k >= 0; k--) begin
            adv[k]     = valid_q[k] & down_ready;
            en[k]      = ~valid_q[k] | adv[k];
            down_ready = en[k];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // ---------------------------------------------------------------------
    // Datapath: stage gi adds segment gi. It keeps the finished low sum bits
    // and only the operand bits that later stages still need.
    // ---------------------------------------------------------------------
    genvar gi;
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
        localparam int LO  = gi * SEG;
        localparam int HI  = LO + SEG;
        localparam int OPW = WIDTH - LO;

        logic [OPW-1:0] a_src;
        logic [OPW-1:0] b_src;
        logic           c_src;
        logic           v_src;
        logic [SEG:0]   seg_res;
        logic [HI-1:0]  sum_d;
        logic [HI-1:0]  sum_q;
        logic           c_q;

        if (gi == 0) begin : g_first
            // Subtraction is a + ~b + 1.
            assign a_src = in1;
            assign b_src = sub ? ~in2 : in2;
            assign c_src = sub ? 1'b1 : cin;
            assign v_src = in_valid;
            assign sum_d = seg_res[SEG-1:0];
        end else begin : g_next
            assign a_src = g_stage[gi-1].g_carry_ops.a_q;
            assign b_src = g_stage[gi-1].g_carry_ops.b_q;
            assign c_src = g_stage[gi-1].c_q;
            assign v_src = valid_q[gi-1];
            assign sum_d = {seg_res[SEG-1:0], g_stage[gi-1].sum_q};
        end

        assign seg_res     = cla_segment(a_src[SEG-1:0], b_src[SEG-1:0], c_src);
        assign valid_d[gi] = en[gi] ? v_src : valid_q[gi];

        // Data registers carry no reset; valid_q alone marks them meaningful.
        always_ff @(posedge clk) begin
            if (en[gi]) begin
                sum_q <= sum_d;
                c_q   <= seg_res[SEG];
            end
        end

        if (gi < LAST) begin : g_carry_ops
            logic [OPW-SEG-1:0] a_q;
            logic [OPW-SEG-1:0] b_q;
            always_ff @(posedge clk) begin
                if (en[gi]) begin
                    a_q <= a_src[OPW-1:SEG];
                    b_q <= b_src[OPW-1:SEG];
                end
            end
        end
    end

    assign in_ready  = en[0];
    assign out_valid = valid_q[LAST];
    assign s         = {g_stage[LAST].c_q, g_stage[LAST].sum_q};

endmodule
